mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
Memory stage plus MEM/WB pipeline register. Sits directly upstream of the write-back stage and produces its inputs: mem_read, WB_en, dst, ALU_res, mem. Data memory is an external 16-bit SRAM, so each 32-bit access takes two half-word transfers with programmable wait cycles. While an access is in flight, the block drops ready to freeze the upstream pipeline.

Parameters:
WORD_WIDTH, 32, datapath word width
REG_FILE_DEPTH, 4, destination register index width
SRAM_ADDR_WIDTH, 18, external SRAM half-word address width
SRAM_DATA_WIDTH, 16, external SRAM data width (fixed at WORD_WIDTH/2)
WAIT_CYCLES, 1, extra cycles each half-word transfer is held (0..7)
BASE_ADDR, 1024, byte address mapped to SRAM word 0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
mem_read_in  in  1  EX/MEM load request
mem_write_in  in  1  EX/MEM store request
WB_en_in  in  1  EX/MEM write-back enable
dst_in  in  REG_FILE_DEPTH  EX/MEM destination register
ALU_res_in  in  WORD_WIDTH  effective address, or ALU result
Val_Rm_in  in  WORD_WIDTH  store data
ready  out  1  1 = stage not stalling; upstream freezes when 0
mem_read  out  1  MEM/WB: selects memory data in write-back
WB_en  out  1  MEM/WB write-back enable
dst  out  REG_FILE_DEPTH  MEM/WB destination
ALU_res  out  WORD_WIDTH  MEM/WB ALU result
mem  out  WORD_WIDTH  MEM/WB load data
sram_addr  out  SRAM_ADDR_WIDTH  half-word address
sram_dq_out  out  16  write data
sram_dq_oe  out  1  1 = drive sram_dq_out
sram_dq_in  in  16  read data
sram_we_n  out  1  active-low write strobe
sram_oe_n  out  1  active-low output enable

Behaviour:
- Request: req = mem_read_in | mem_write_in. If both are set, the read wins and no write strobe is issued.
- Address:
  - idx = (ALU_res_in - BASE_ADDR) >> 2, modulo 2^32 (wrap-around).
  - Low half-word address = {idx, 0}; high half-word address = {idx, 1}; both truncated to SRAM_ADDR_WIDTH.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on req, go to LO.
  - LO: hold for WAIT_CYCLES+1 cycles, then go to HI.
  - HI: hold for WAIT_CYCLES+1 cycles, then go to DONE.
  - DONE: go to IDLE unconditionally.
- ready = (IDLE & ~req) | DONE, combinational. Upstream inputs stay stable while ready=0.
- Stall length for a memory operation: 1 + 2*(WAIT_CYCLES+1) cycles with ready=0, then a single DONE cycle with ready=1 (6 cycles total for WAIT_CYCLES=1). A request present in the DONE cycle is the already-served one; the FSM does not restart from DONE.
- Read:
  - sram_oe_n=0 throughout LO and HI.
  - Low half is latched from sram_dq_in on the last LO cycle; high half on the last HI cycle.
  - Load data = {hi, lo}.
- Write:
  - sram_dq_oe=1 and sram_we_n=0 in LO/HI, except on the final cycle of each phase, where sram_we_n=1 so the address is stable across the strobe's rising edge.
  - Data: Val_Rm_in[15:0] in LO, Val_Rm_in[31:16] in HI.
- Idle SRAM controls: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr held at its last value.
- MEM/WB register:
  - When ready=1, loads mem_read_in, WB_en_in, dst_in, ALU_res_in and the load data. For non-memory instructions this is the same cycle they arrive, i.e. one-cycle latency.
  - When ready=0, loads a bubble: WB_en=0, mem_read=0; other fields hold.
- Reset (any time, including mid-access):
  - FSM returns to IDLE and the wait counter goes to 0.
  - All MEM/WB outputs go to 0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0.
  - A partially written word is left as-is and is not retried.

Optional Feature:
MEM_ACCESS_CNT_EN
- Defined: adds two 32-bit outputs.
  - access_cnt increments once per completed memory operation (on the DONE cycle).
  - stall_cnt increments on every cycle with ready=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- constants.h: WORD_WIDTH, REG_FILE_DEPTH, SRAM_ADDR_WIDTH, SRAM_DATA_WIDTH, BASE_ADDR, FSM state encodings (2-bit).
- Sub-module sram_controller: FSM, wait counter, half-word latching, SRAM pins, ready.
- Top mem_stage_sram: address mapping and MEM/WB register.

Test Plan:
- Non-memory op: WB_en_in=1, dst_in=5, ALU_res_in=0x1234 -> ready stays 1; next cycle WB_en=1, dst=5, ALU_res=0x1234, mem_read=0.
- Store then load, WAIT_CYCLES=1:
  - Store: ALU_res_in=1032, Val_Rm_in=0xDEADBEEF -> ready low for 5 cycles; SRAM addresses 4/5 receive 0xBEEF/0xDEAD; WB_en=0 bubbles during the stall.
  - Load: same address, dst_in=3 -> mem=0xDEADBEEF, mem_read=1, WB_en=1, dst=3.
- WAIT_CYCLES=0: load -> ready low for exactly 3 cycles.
- mem_read_in and mem_write_in both 1 -> sram_we_n never 0; load data returned.
- rst asserted in HI of a store -> next sample: outputs 0, sram_we_n=1, state IDLE, ready=1 with req=0.
- MEM_ACCESS_CNT_EN defined, three back-to-back loads at WAIT_CYCLES=1 -> access_cnt=3, stall_cnt=15.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// Shared constants, FSM encoding and address helper for the memory stage and its SRAM controller.
// Optional feature macro (used by mem_stage_sram): MEM_ACCESS_CNT_EN.
package mem_stage_sram_pkg;

  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned REG_FILE_DEPTH  = 4;
  localparam int unsigned SRAM_ADDR_WIDTH = 18;
  localparam int unsigned SRAM_DATA_WIDTH = WORD_WIDTH / 2;
  localparam logic [WORD_WIDTH-1:0] BASE_ADDR = 32'd1024;
  localparam int unsigned WAIT_CNT_WIDTH  = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2,
    StDone = 2'd3
  } mem_state_e;

  // Half-word SRAM address for a byte address; the subtraction wraps modulo 2^32.
  function automatic logic [SRAM_ADDR_WIDTH-1:0] half_addr(input logic [WORD_WIDTH-1:0] byte_addr,
                                                           input logic hi);
    logic [WORD_WIDTH-1:0] idx;
    idx = (byte_addr - BASE_ADDR) >> 2;
    return SRAM_ADDR_WIDTH'({idx, hi});
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// SRAM controller: splits one 32-bit access into two 16-bit transfers, each held for
// WAIT_CYCLES+1 cycles, and reports ready while no access is outstanding.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   mem_read_in, mem_write_in  access request (read wins when both are set)
//   lo_addr, hi_addr           half-word addresses of the current word
//   wr_data                    store data
//   ready, done                stage not stalling / last cycle of an access
//   load_data                  {high, low} half-words of the last load
//   sram_*                     external SRAM pins (registered)
module mem_stage_sram_ctrl
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [SRAM_ADDR_WIDTH-1:0] lo_addr,
  input  logic [SRAM_ADDR_WIDTH-1:0] hi_addr,
  input  logic [WORD_WIDTH-1:0]      wr_data,
  output logic                       ready,
  output logic                       done,
  output logic [WORD_WIDTH-1:0]      load_data,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LastCnt = WAIT_CNT_WIDTH'(WAIT_CYCLES);
  // With no wait cycles every phase is a single cycle, which is also its final cycle.
  localparam bit FirstIsLast = (WAIT_CYCLES == 0);

  mem_state_e                 state_q;
  logic [WAIT_CNT_WIDTH-1:0]  cnt_q;
  logic [SRAM_DATA_WIDTH-1:0] lo_q, hi_q;

  logic req, wr_only, phase_end, strobe_start, strobe_mid;

  always_comb begin
    req          = mem_read_in | mem_write_in;
    wr_only      = mem_write_in & ~mem_read_in;
    phase_end    = (cnt_q == LastCnt);
    // Strobe is low except on the final cycle of each phase so the address is stable
    // across its rising edge.
    strobe_start = wr_only & ~FirstIsLast;
    strobe_mid   = wr_only & ((cnt_q + 3'd1) != LastCnt);
    ready        = ((state_q == StIdle) & ~req) | (state_q == StDone);
    done         = (state_q == StDone);
    load_data    = {hi_q, lo_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q     <= StLo;
            cnt_q       <= '0;
            sram_addr   <= lo_addr;
            sram_dq_out <= wr_data[SRAM_DATA_WIDTH-1:0];
            sram_dq_oe  <= wr_only;
            sram_oe_n   <= ~mem_read_in;
            sram_we_n   <= ~strobe_start;
          end
        end
        StLo: begin
          if (phase_end) begin
            if (mem_read_in) lo_q <= sram_dq_in;
            state_q     <= StHi;
            cnt_q       <= '0;
            sram_addr   <= hi_addr;
            sram_dq_out <= wr_data[WORD_WIDTH-1:SRAM_DATA_WIDTH];
            sram_we_n   <= ~strobe_start;
          end else begin
            cnt_q     <= cnt_q + 3'd1;
            sram_we_n <= ~strobe_mid;
          end
        end
        StHi: begin
          if (phase_end) begin
            if (mem_read_in) hi_q <= sram_dq_in;
            state_q    <= StDone;
            cnt_q      <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + 3'd1;
            sram_we_n <= ~strobe_mid;
          end
        end
        StDone: begin
          // The request still present here is the one just served.
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage with MEM/WB pipeline register, backed by an external 16-bit SRAM.
// Optional feature: define MEM_ACCESS_CNT_EN to add access_cnt / stall_cnt outputs.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   *_in                            EX/MEM register fields
//   ready                           0 freezes the upstream pipeline
//   mem_read, WB_en, dst, ALU_res, mem   MEM/WB register outputs
//   sram_*                          external SRAM pins
//   access_cnt, stall_cnt           completed accesses / stalled cycles (optional)
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       WB_en_in,
  input  logic [REG_FILE_DEPTH-1:0]  dst_in,
  input  logic [WORD_WIDTH-1:0]      ALU_res_in,
  input  logic [WORD_WIDTH-1:0]      Val_Rm_in,
  output logic                       ready,
  output logic                       mem_read,
  output logic                       WB_en,
  output logic [REG_FILE_DEPTH-1:0]  dst,
  output logic [WORD_WIDTH-1:0]      ALU_res,
  output logic [WORD_WIDTH-1:0]      mem,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  output logic                       sram_dq_oe,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]                access_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  logic [SRAM_ADDR_WIDTH-1:0] lo_addr, hi_addr;
  logic [WORD_WIDTH-1:0]      load_data;
  logic                       done;

  always_comb begin
    lo_addr = half_addr(ALU_res_in, 1'b0);
    hi_addr = half_addr(ALU_res_in, 1'b1);
  end

  mem_stage_sram_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mem_read_in (mem_read_in),
    .mem_write_in(mem_write_in),
    .lo_addr     (lo_addr),
    .hi_addr     (hi_addr),
    .wr_data     (Val_Rm_in),
    .ready       (ready),
    .done        (done),
    .load_data   (load_data),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  // MEM/WB register: bubbles (no write-back) while the stage is stalling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read <= 1'b0;
      WB_en    <= 1'b0;
      dst      <= '0;
      ALU_res  <= '0;
      mem      <= '0;
    end else if (ready) begin
      mem_read <= mem_read_in;
      WB_en    <= WB_en_in;
      dst      <= dst_in;
      ALU_res  <= ALU_res_in;
      mem      <= load_data;
    end else begin
      mem_read <= 1'b0;
      WB_en    <= 1'b0;
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      access_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (done)   access_cnt <= access_cnt + 32'd1;
      if (!ready) stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam logic [31:0] BASE = 32'd1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b1;  // 1: drive the WAIT_CYCLES=1 instance, 0: the WAIT_CYCLES=0 instance

  logic        d_mr = 1'b0, d_mw = 1'b0, d_wb = 1'b0;
  logic [3:0]  d_dst = '0;
  logic [31:0] d_alu = '0, d_val = '0;

  logic        r1_ready, r1_mr, r1_wb, r1_oe, r1_we, r1_oen;
  logic [3:0]  r1_dst;
  logic [31:0] r1_alu, r1_mem;
  logic [17:0] r1_addr;
  logic [15:0] r1_dq;
  logic        r0_ready, r0_mr, r0_wb, r0_oe, r0_we, r0_oen;
  logic [3:0]  r0_dst;
  logic [31:0] r0_alu, r0_mem;
  logic [17:0] r0_addr;
  logic [15:0] r0_dq;
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] c1_acc, c1_stall, c0_acc, c0_stall;
`endif

  logic        o_ready, o_mr, o_wb, o_oe, o_we, o_oen;
  logic [3:0]  o_dst;
  logic [31:0] o_alu, o_mem;
  logic [17:0] o_addr;
  logic [15:0] o_dq, dq_in;

  assign o_ready = sel ? r1_ready : r0_ready;
  assign o_mr    = sel ? r1_mr    : r0_mr;
  assign o_wb    = sel ? r1_wb    : r0_wb;
  assign o_dst   = sel ? r1_dst   : r0_dst;
  assign o_alu   = sel ? r1_alu   : r0_alu;
  assign o_mem   = sel ? r1_mem   : r0_mem;
  assign o_addr  = sel ? r1_addr  : r0_addr;
  assign o_dq    = sel ? r1_dq    : r0_dq;
  assign o_oe    = sel ? r1_oe    : r0_oe;
  assign o_we    = sel ? r1_we    : r0_we;
  assign o_oen   = sel ? r1_oen   : r0_oen;

  mem_stage_sram #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_read_in(sel & d_mr), .mem_write_in(sel & d_mw), .WB_en_in(sel & d_wb),
    .dst_in(d_dst), .ALU_res_in(d_alu), .Val_Rm_in(d_val),
    .ready(r1_ready), .mem_read(r1_mr), .WB_en(r1_wb), .dst(r1_dst), .ALU_res(r1_alu),
    .mem(r1_mem), .sram_addr(r1_addr), .sram_dq_out(r1_dq), .sram_dq_oe(r1_oe),
    .sram_dq_in(dq_in), .sram_we_n(r1_we), .sram_oe_n(r1_oen)
`ifdef MEM_ACCESS_CNT_EN
    , .access_cnt(c1_acc), .stall_cnt(c1_stall)
`endif
  );

  mem_stage_sram #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .mem_read_in(~sel & d_mr), .mem_write_in(~sel & d_mw), .WB_en_in(~sel & d_wb),
    .dst_in(d_dst), .ALU_res_in(d_alu), .Val_Rm_in(d_val),
    .ready(r0_ready), .mem_read(r0_mr), .WB_en(r0_wb), .dst(r0_dst), .ALU_res(r0_alu),
    .mem(r0_mem), .sram_addr(r0_addr), .sram_dq_out(r0_dq), .sram_dq_oe(r0_oe),
    .sram_dq_in(dq_in), .sram_we_n(r0_we), .sram_oe_n(r0_oen)
`ifdef MEM_ACCESS_CNT_EN
    , .access_cnt(c0_acc), .stall_cnt(c0_stall)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: low 8 address bits index a small array; writes while the strobe is low.
  logic [15:0] sram [256];
  bit          sram_init = 1'b0;
  assign dq_in = !o_oen ? sram[o_addr[7:0]] : 16'h0000;

  always @(negedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
      sram_init <= 1'b1;
    end else if (!o_we && o_oe) begin
      sram[o_addr[7:0]] <= o_dq;
    end
  end

  // Reference model: word contents by word index.
  logic [31:0] model_mem [int unsigned];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM pin expectations for cycle k of an instruction (k=0 is the arrival cycle).
  task automatic check_pins(input bit req, input bit mr, input int w, input int k, input int s,
                            input logic [31:0] idx, input logic [31:0] val);
    bit          hi;
    int          kk, j;
    logic [17:0] ea;
    if (!req || k < 1 || k >= s) begin
      chk("idle_we_n", o_we, 1);
      chk("idle_oe_n", o_oen, 1);
      chk("idle_dq_oe", o_oe, 0);
    end else begin
      kk = k - 1;
      hi = (kk >= w + 1);
      j  = hi ? kk - (w + 1) : kk;
      ea = {idx[16:0], hi};
      chk("sram_addr", o_addr, ea);
      if (mr) begin
        chk("rd_oe_n", o_oen, 0);
        chk("rd_dq_oe", o_oe, 0);
        chk("rd_we_n", o_we, 1);
      end else begin
        chk("wr_oe_n", o_oen, 1);
        chk("wr_dq_oe", o_oe, 1);
        chk("wr_we_n", o_we, (j == w));
        chk("wr_dq", o_dq, hi ? val[31:16] : val[15:0]);
      end
    end
  endtask

  // Applies one instruction at posedge+1 and holds it until the stage accepts it,
  // then checks the MEM/WB register one edge later.
  task automatic do_instr(input logic mr, input logic mw, input logic wb, input logic [3:0] dst,
                          input logic [31:0] alu, input logic [31:0] val, output int stall);
    int          w, s, k;
    bit          req, fin;
    logic [31:0] idx, exp_mem;
    w   = sel ? 1 : 0;
    req = mr | mw;
    s   = req ? 1 + 2 * (w + 1) : 0;
    idx = (alu - BASE) >> 2;
    exp_mem = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    d_mr = mr; d_mw = mw; d_wb = wb; d_dst = dst; d_alu = alu; d_val = val;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      check_pins(req, mr, w, k, s, idx, val);
      if (o_ready) begin
        chk("stall_len", k, s);
        fin = 1'b1;
      end else begin
        if (k >= 1) begin
          chk("bubble_wb", o_wb, 0);
          chk("bubble_mr", o_mr, 0);
        end
        if (k >= 40) begin
          chk("stall_timeout", k, s);
          fin = 1'b1;
        end
      end
      if (!fin) k++;
      @(posedge clk);
      #1;
    end
    stall = k;
    chk("wb_en", o_wb, wb);
    chk("wb_mem_read", o_mr, mr);
    chk("wb_dst", o_dst, dst);
    chk("wb_alu", o_alu, alu);
    if (mr) chk("wb_mem", o_mem, exp_mem);
    if (mw && !mr && w > 0) model_mem[idx] = val;
  endtask

  task automatic rand_instr(input bit allow_store);
    int          op, st;
    logic [31:0] a;
    op = $urandom_range(0, 3);
    if (!allow_store && op == 2) op = 1;
    a = ($urandom_range(0, 7) == 0) ? BASE - 32'd4 : BASE + 32'd4 * $urandom_range(0, 31);
    a = a + $urandom_range(0, 3);
    unique case (op)
      0: do_instr(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, st);
      1: do_instr(1'b1, 1'b0, 1'b1, 4'($urandom), a, $urandom, st);
      2: do_instr(1'b0, 1'b1, 1'b0, 4'($urandom), a, $urandom, st);
      default: do_instr(1'b1, 1'b1, 1'b1, 4'($urandom), a, $urandom, st);
    endcase
  endtask

  initial begin
    int st;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_en", o_wb, 0);
    chk("rst_dst", o_dst, 0);
    chk("rst_alu", o_alu, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_ready", o_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

`ifdef MEM_ACCESS_CNT_EN
    repeat (3) do_instr(1'b1, 1'b0, 1'b1, 4'd1, BASE, 32'h0, st);
    chk("access_cnt", c1_acc, 3);
    chk("stall_cnt", c1_stall, 15);
    chk("access_cnt_other", c0_acc, 0);
    chk("stall_cnt_other", c0_stall, 0);
`endif

    // Non-memory instruction: one-cycle latency, no stall.
    do_instr(1'b0, 1'b0, 1'b1, 4'd5, 32'h1234, 32'h0, st);
    chk("nonmem_stall", st, 0);
    chk("nonmem_alu", o_alu, 32'h1234);
    chk("nonmem_dst", o_dst, 5);

    // Store then load of the same word.
    do_instr(1'b0, 1'b1, 1'b0, 4'd0, 32'd1032, 32'hDEADBEEF, st);
    chk("store_stall", st, 5);
    chk("sram_lo_word4", sram[4], 16'hBEEF);
    chk("sram_hi_word5", sram[5], 16'hDEAD);
    do_instr(1'b1, 1'b0, 1'b1, 4'd3, 32'd1032, 32'h0, st);
    chk("load_data", o_mem, 32'hDEADBEEF);
    chk("load_dst", o_dst, 3);
    chk("load_mem_read", o_mr, 1);

    // Zero wait cycles: three stalled cycles.
    sel = 1'b0;
    do_instr(1'b1, 1'b0, 1'b1, 4'd7, 32'd1032, 32'h0, st);
    chk("w0_load_stall", st, 3);
    chk("w0_load_data", o_mem, 32'hDEADBEEF);

    // Read and write together: read wins.
    sel = 1'b1;
    do_instr(1'b1, 1'b1, 1'b1, 4'd2, 32'd1032, 32'h11112222, st);
    chk("rw_load_data", o_mem, 32'hDEADBEEF);

    repeat (40) rand_instr(1'b1);

    // Reset in the high phase of a store.
    d_mr = 1'b0; d_mw = 1'b1; d_wb = 1'b0; d_dst = 4'd9;
    d_alu = BASE + 32'd240; d_val = 32'hCAFEF00D;
    repeat (4) @(negedge clk);
    chk("pre_rst_we_n", o_we, 0);
    chk("pre_rst_addr", o_addr, 18'd121);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wb_en", o_wb, 0);
    chk("mid_rst_mem_read", o_mr, 0);
    chk("mid_rst_dst", o_dst, 0);
    chk("mid_rst_alu", o_alu, 0);
    chk("mid_rst_mem", o_mem, 0);
    chk("mid_rst_we_n", o_we, 1);
    chk("mid_rst_oe_n", o_oen, 1);
    chk("mid_rst_dq_oe", o_oe, 0);
    chk("mid_rst_addr", o_addr, 0);
    d_mw = 1'b0; d_dst = 4'd0; d_alu = 32'h0; d_val = 32'h0;
    #1;
    chk("mid_rst_ready", o_ready, 1);
`ifdef MEM_ACCESS_CNT_EN
    chk("mid_rst_access_cnt", c1_acc, 0);
    chk("mid_rst_stall_cnt", c1_stall, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", o_ready, 1);

    repeat (10) rand_instr(1'b1);
    sel = 1'b0;
    repeat (12) rand_instr(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
